// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS core and its data-memory responder.
//   state_t        responder FSM encoding (IDLE, WAIT, ACCESS, RESP)
//   WORD_BYTES     bytes per data word
//   OP_LW / OP_SW  load/store opcodes, also used by the control unit
//   is_misaligned  true when a byte address is not word aligned
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int unsigned WORD_BYTES = 32'd4;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  // Word accesses must have the two byte-offset bits clear.
  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return (byte_off != 2'd0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word RAM, synchronous write and synchronous read.
//   clk    system clock
//   we     write enable; mem[idx] <= wdata on the rising edge
//   idx    word index (shared by read and write)
//   wdata  write data
//   rdata  registered read data: mem[idx] as sampled on the last rising edge
// Contents are never reset.
module dmem_array #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage write and registered read of the addressed word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
    rdata_q <= mem_q[idx];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: turns the core's load/store access into a valid/ready
// request/response transaction with WAIT_CYCLES programmable wait states.
//   clk, reset          clock, asynchronous active-high reset
//   req_valid/req_ready request handshake; req_ready is 1 only in IDLE
//   req_write           1 = store, 0 = load
//   req_addr/req_wdata  byte address and store data
//   resp_valid/ready    response handshake; outputs held until accepted
//   resp_rdata          load data (0 for stores and errors)
//   resp_err            misaligned or out-of-range access
module dmem_responder
  import mips_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int                IDX_W     = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
  localparam logic [3:0]        WAIT_INIT = 4'(WAIT_CYCLES);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic [ADDR_W-1:0] word_addr;
  logic              acc_err;
  logic [IDX_W-1:0]  arr_idx;
  logic              arr_we;
  logic [DATA_W-1:0] arr_rdata;

  // Upper address bits are kept so that large addresses fail the range check
  // instead of aliasing onto a low word.
  assign word_addr = addr_q >> 2;
  assign acc_err   = is_misaligned(addr_q[1:0]) | (word_addr >= DEPTH_A);

  // In IDLE the array already reads the incoming address, so the synchronous
  // read result is ready in the ACCESS cycle even with zero wait states.
  assign arr_idx = (state_q == IDLE) ? req_addr[IDX_W+1:2] : addr_q[IDX_W+1:2];
  assign arr_we  = (state_q == ACCESS) & write_q & ~acc_err;

  dmem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .idx   (arr_idx),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  // Next-state and registered-output logic of the transaction FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          write_d     = req_write;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          req_ready_d = 1'b0;
          if (WAIT_CYCLES == 0) begin
            state_d = ACCESS;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ACCESS;
        end else begin
          state_d = WAIT;
        end
      end
      ACCESS: begin
        resp_valid_d = 1'b1;
        resp_err_d   = acc_err;
        if (!write_q && !acc_err) begin
          resp_rdata_d = arr_rdata;
        end else begin
          resp_rdata_d = {DATA_W{1'b0}};
        end
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_rdata_d = {DATA_W{1'b0}};
          resp_err_d   = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      addr_q       <= {ADDR_W{1'b0}};
      wdata_q      <= {DATA_W{1'b0}};
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= {DATA_W{1'b0}};
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
